census_window: RTL

Streaming census-transform stage for the stereo matcher. It accepts one raster-order pixel per valid cycle and keeps WIN-1 image rows in tapped-FIFO line buffers. It assembles a WIN×WIN neighbourhood and emits a (WIN·WIN-1)-bit census signature for each window that lies fully inside the image. It sits directly upstream of the disparity/Hamming-cost stage and downstream of the pixel source.

---
 rtl/census_window.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/census_window.sv
// rtl/census_window.sv - streaming WINxWIN census transform over a raster pixel stream
//
// Purpose: keeps WIN-1 image rows in chained tapped line buffers, assembles a
// WINxWIN window per accepted pixel and emits a (WIN*WIN-1)-bit census
// signature (bit = neighbour < centre, top-left at the MSB, centre skipped).
// Optional feature macro: CENSUS_BORDER_EN (emit for every pixel, zero
// signature on incomplete windows).
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-low reset
//   in_valid   in   in_pixel accepted this cycle
//   in_pixel   in   WIDTH-bit pixel, raster order
//   out_valid  out  one-cycle pulse, out_census holds a new signature
//   out_census out  WIN*WIN-1 bit census signature
module census_window #(
  parameter int WIDTH = 8,
  parameter int IMG_W = 64,
  parameter int IMG_H = 48,
  parameter int WIN   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_pixel,
  output logic                 out_valid,
  output logic [WIN*WIN-2:0]   out_census
);

  localparam int NB   = WIN * WIN - 1;
  localparam int CI   = (WIN - 1) / 2;
  localparam int CIDX = CI * WIN + CI;
  localparam int CW   = $clog2(IMG_W);
  localparam int RW   = $clog2(IMG_H);

  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_MIN = CW'(WIN - 1);
  localparam logic [RW-1:0] ROW_MIN = RW'(WIN - 1);

  logic [WIDTH-1:0] lb      [WIN-1][IMG_W];
  logic [WIDTH-1:0] win     [WIN][WIN];
  logic [WIDTH-1:0] nxt_win [WIN][WIN];
  logic [CW-1:0]    col;
  logic [RW-1:0]    row;
  logic             complete;
  logic [NB-1:0]    census;

  // Window as it will look after the current pixel is accepted; the census is
  // taken from it so the signature registers on the accepting edge.
  always_comb begin
    nxt_win = win;
    for (int r = 0; r < WIN; r++) begin
      for (int c = 0; c < WIN - 1; c++) begin
        nxt_win[r][c] = win[r][c+1];
      end
    end
    nxt_win[WIN-1][WIN-1] = in_pixel;
    // line buffer k delivers the pixel k+1 rows above: oldest row on top
    for (int k = 0; k < WIN - 1; k++) begin
      nxt_win[WIN-2-k][WIN-1] = lb[k][IMG_W-1];
    end
  end

  assign complete = (row >= ROW_MIN) && (col >= COL_MIN);

  // Row-major neighbour ordinal n (centre skipped) maps to bit NB-1-n.
  always_comb begin
    census = '0;
    for (int r = 0; r < WIN; r++) begin
      for (int c = 0; c < WIN; c++) begin
        if ((r * WIN + c) != CIDX) begin
          census[NB - 1 - ((r * WIN + c) - (((r * WIN + c) > CIDX) ? 1 : 0))] =
            (nxt_win[r][c] < nxt_win[CI][CI]);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < WIN - 1; k++) begin
        for (int i = 0; i < IMG_W; i++) begin
          lb[k][i] <= '0;
        end
      end
    end else if (in_valid) begin
      for (int k = 0; k < WIN - 1; k++) begin
        lb[k][0] <= (k == 0) ? in_pixel : lb[(k == 0) ? 0 : k-1][IMG_W-1];
        for (int i = 1; i < IMG_W; i++) begin
          lb[k][i] <= lb[k][i-1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < WIN; r++) begin
        for (int c = 0; c < WIN; c++) begin
          win[r][c] <= '0;
        end
      end
    end else if (in_valid) begin
      win <= nxt_win;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col <= '0;
      row <= '0;
    end else if (in_valid) begin
      if (col == COL_MAX) begin
        col <= '0;
        row <= (row == ROW_MAX) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      out_census <= '0;
    end else begin
`ifdef CENSUS_BORDER_EN
      out_valid <= in_valid;
      if (in_valid) begin
        out_census <= complete ? census : '0;
      end
`else
      out_valid <= in_valid && complete;
      if (in_valid && complete) begin
        out_census <= census;
      end
`endif
    end
  end

endmodule
